// File: rtl/pipe_addsub.sv
// Pipelined add/subtract unit with valid/ready on both sides, an in-order tag
// sideband and optional saturation. Each stage holds {valid, flag+result, tag}.
module pipe_addsub #(
  parameter int WIDTH    = 8,
  parameter int LATENCY  = 3,
  parameter int SATURATE = 0,
  parameter int TAG_W    = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               in_op,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH:0]     out_sum,
  output logic [TAG_W-1:0]   out_tag
);

  // Handshake: a transfer happens on a rising edge when valid && ready on that
  // port; in_ready never depends on in_valid and out_valid never depends on in_valid.

  logic               s_valid [LATENCY];
  logic [WIDTH:0]     s_sum   [LATENCY];
  logic [TAG_W-1:0]   s_tag   [LATENCY];
  logic [LATENCY-1:0] s_load;
  logic               run;
  logic               in_fire;
  logic [WIDTH:0]     raw;
  logic [WIDTH:0]     res;

  // A stage may take new contents when it, or any stage after it, is empty,
  // or when the tail is being drained this cycle (bubbles collapse).
  always_comb begin
    logic free;
    free   = out_ready;
    s_load = '0;
    for (int i = LATENCY - 1; i >= 0; i--) begin
      free      = free || !s_valid[i];
      s_load[i] = free;
    end
  end

  assign in_ready = run && s_load[0];
  assign in_fire  = in_valid && in_ready;

  // Bit WIDTH of the widened sum/difference is the carry or the borrow.
  always_comb begin
    raw = in_op ? ({1'b0, in_a} - {1'b0, in_b}) : ({1'b0, in_a} + {1'b0, in_b});
    res = raw;
    if (SATURATE != 0 && raw[WIDTH]) begin
      res[WIDTH-1:0] = in_op ? '0 : '1;
    end
  end

  // in_ready stays low until the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) run <= 1'b0;
    else        run <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LATENCY; i++) begin
        s_valid[i] <= 1'b0;
        s_sum[i]   <= '0;
        s_tag[i]   <= '0;
      end
    end else begin
      for (int i = LATENCY - 1; i >= 1; i--) begin
        if (s_load[i]) begin
          s_valid[i] <= s_valid[i-1];
          if (s_valid[i-1]) begin
            s_sum[i] <= s_sum[i-1];
            s_tag[i] <= s_tag[i-1];
          end
        end
      end
      if (s_load[0]) begin
        s_valid[0] <= in_fire;
        if (in_fire) begin
          s_sum[0] <= res;
          s_tag[0] <= in_tag;
        end
      end
    end
  end

  assign out_valid = s_valid[LATENCY-1];
  assign out_sum   = s_sum[LATENCY-1];
  assign out_tag   = s_tag[LATENCY-1];

endmodule

// File: tb/tb_pipe_addsub.sv
// Bench for pipe_addsub: a wrapping and a saturating instance share stimulus;
// each has its own expected queue and monitor.
module tb_pipe_addsub;

  localparam int W  = 8;
  localparam int L  = 3;
  localparam int TW = 4;
  localparam int EW = W + 1 + TW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [W-1:0]  in_a = '0;
  logic [W-1:0]  in_b = '0;
  logic          in_op = 1'b0;
  logic [TW-1:0] in_tag = '0;
  logic          out_ready = 1'b1;

  logic          ready0, ready1, valid0, valid1;
  logic [W:0]    sum0, sum1;
  logic [TW-1:0] tag0, tag1;

  logic [EW-1:0] exp0_q[$];
  logic [EW-1:0] exp1_q[$];
  int checks = 0;
  int errors = 0;
  int acc_cnt = 0;

  always #5 clk = ~clk;

  pipe_addsub #(.WIDTH(W), .LATENCY(L), .SATURATE(0), .TAG_W(TW)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ready0),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_tag(in_tag),
    .out_valid(valid0), .out_ready(out_ready), .out_sum(sum0), .out_tag(tag0));

  pipe_addsub #(.WIDTH(W), .LATENCY(L), .SATURATE(1), .TAG_W(TW)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ready1),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_tag(in_tag),
    .out_valid(valid1), .out_ready(out_ready), .out_sum(sum1), .out_tag(tag1));

  // Directed vectors: a, b, op, tag, expected wrap result, expected saturated result.
  localparam int NV = 12;
  logic [W-1:0]  va   [NV] = '{8'd200, 8'd5,  8'd10, 8'd255, 8'd100, 8'd0,  8'd0,  8'd128, 8'd255, 8'd127, 8'd1,  8'd200};
  logic [W-1:0]  vb   [NV] = '{8'd100, 8'd10, 8'd5,  8'd255, 8'd27,  8'd0,  8'd1,  8'd128, 8'd0,   8'd128, 8'd255, 8'd55};
  logic          vop  [NV] = '{1'b0,   1'b1,  1'b1,  1'b0,   1'b0,   1'b1,  1'b1,  1'b0,   1'b1,   1'b0,   1'b1,  1'b0};
  logic [W:0]    vexp0[NV] = '{9'h12C, 9'h1FB, 9'h005, 9'h1FE, 9'h07F, 9'h000, 9'h1FF, 9'h100, 9'h0FF, 9'h0FF, 9'h102, 9'h0FF};
  logic [W:0]    vexp1[NV] = '{9'h1FF, 9'h100, 9'h005, 9'h1FF, 9'h07F, 9'h000, 9'h100, 9'h1FF, 9'h0FF, 9'h0FF, 9'h100, 9'h0FF};

  // Back-pressure burst: adds with tags 0..5.
  logic [W-1:0]  ba   [6] = '{8'd1, 8'd10, 8'd100, 8'd200, 8'd0, 8'd255};
  logic [W-1:0]  bb   [6] = '{8'd2, 8'd20, 8'd100, 8'd56,  8'd0, 8'd1};
  logic [W:0]    bexp0[6] = '{9'h003, 9'h01E, 9'h0C8, 9'h100, 9'h000, 9'h100};
  logic [W:0]    bexp1[6] = '{9'h003, 9'h01E, 9'h0C8, 9'h1FF, 9'h000, 9'h1FF};

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, got, want);
    end
  endtask

  // Drives one transaction; inputs change 1 time unit after a rising edge.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic op,
                      input logic [TW-1:0] tag, input logic [W:0] e0, input logic [W:0] e1);
    bit done = 0;
    in_valid = 1'b1; in_a = a; in_b = b; in_op = op; in_tag = tag;
    for (int t = 0; t < 200 && !done; t++) begin
      @(negedge clk);
      if (ready0 && ready1) begin
        exp0_q.push_back({e0, tag});
        exp1_q.push_back({e1, tag});
        acc_cnt++;
        done = 1;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!done) begin
      errors++;
      $display("FAIL send_timeout tag=%0d never accepted within 200 cycles", tag);
    end
  endtask

  task automatic drain();
    int t = 0;
    while ((exp0_q.size() != 0 || exp1_q.size() != 0) && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    chk("drain_left0", exp0_q.size(), 0);
    chk("drain_left1", exp1_q.size(), 0);
  endtask

  always @(negedge clk) begin
    if (rst_n && valid0 && out_ready) begin
      checks++;
      if (exp0_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out0 got sum=%h tag=%0d with nothing expected", sum0, tag0);
      end else begin
        logic [EW-1:0] e;
        e = exp0_q.pop_front();
        if ({sum0, tag0} !== e) begin
          errors++;
          $display("FAIL result0 got sum=%h tag=%0d expected sum=%h tag=%0d", sum0, tag0, e[EW-1:TW], e[TW-1:0]);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && valid1 && out_ready) begin
      checks++;
      if (exp1_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out1 got sum=%h tag=%0d with nothing expected", sum1, tag1);
      end else begin
        logic [EW-1:0] e;
        e = exp1_q.pop_front();
        if ({sum1, tag1} !== e) begin
          errors++;
          $display("FAIL result1 got sum=%h tag=%0d expected sum=%h tag=%0d", sum1, tag1, e[EW-1:TW], e[TW-1:0]);
        end
      end
    end
  end

  initial begin
    // Reset held for 5 cycles.
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid0", valid0, 0);
    chk("rst_out_valid1", valid1, 0);
    chk("rst_in_ready", ready0 | ready1, 0);
    chk("rst_out_sum0", sum0, 0);
    chk("rst_out_tag0", tag0, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_in_ready0", ready0, 1);
    chk("post_rst_in_ready1", ready1, 1);

    // Latency: accepted at edge E, visible after E+2.
    send(va[0], vb[0], vop[0], 4'd5, vexp0[0], vexp1[0]);
    chk("lat_e0", valid0, 0);
    @(posedge clk); #1;
    chk("lat_e1", valid0, 0);
    @(posedge clk); #1;
    chk("lat_e2", valid0, 1);
    chk("lat_e2_sat", valid1, 1);
    drain();

    // Remaining directed vectors back to back.
    for (int i = 1; i < NV; i++) begin
      send(va[i], vb[i], vop[i], TW'(i), vexp0[i], vexp1[i]);
    end
    drain();

    // Same vectors with idle gaps between them.
    for (int i = 1; i < 5; i++) begin
      send(va[i], vb[i], vop[i], TW'(i + 8), vexp0[i], vexp1[i]);
      repeat (i) @(posedge clk);
      #1;
    end
    drain();

    // Back-pressure: capacity is exactly L, output held steady.
    begin
      int base;
      base = acc_cnt;
      out_ready = 1'b0;
      fork
        begin
          for (int i = 0; i < 6; i++) send(ba[i], bb[i], 1'b0, TW'(i), bexp0[i], bexp1[i]);
        end
        begin
          repeat (8) @(posedge clk);
          #1;
          chk("bp_accepted", acc_cnt - base, L);
          chk("bp_in_ready", ready0, 0);
          chk("bp_out_valid", valid0, 1);
          chk("bp_held_sum0", sum0, 9'h003);
          chk("bp_held_tag0", tag0, 0);
          chk("bp_held_sum1", sum1, 9'h003);
          out_ready = 1'b1;
        end
      join
    end
    drain();

    // Reset while two transactions are in flight.
    send(8'd7, 8'd8, 1'b0, 4'd1, 9'h00F, 9'h00F);
    send(8'd9, 8'd3, 1'b1, 4'd2, 9'h006, 9'h006);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid0", valid0, 0);
    chk("midrst_out_valid1", valid1, 0);
    chk("midrst_in_ready", ready0, 0);
    exp0_q.delete();
    exp1_q.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("no_stale_valid0", valid0, 0);
    chk("no_stale_valid1", valid1, 0);
    send(8'd50, 8'd60, 1'b0, 4'd3, 9'h06E, 9'h06E);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
